muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide controller for the execute stage. It accepts one MULT/MULTU/DIV/DIVU request at a time, sequences a shared radix-4 iterative divider and a registered multiplier, and raises a stall request to hold the pipeline while it works. It returns the 64-bit {HI, LO} result with a one-cycle valid, and supports cancellation on exception flush.

## Interface
- Parameters: none. Constants come from the shared package.
- `cpu_clk_50M`  in  1  sole clock, rising edge.
- `cpu_rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req_valid`  in  1  execute stage holds a mul/div instruction. Operands are stable while `stallreq_o`=1.
- `req_op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `req_src1`  in  32  multiplicand or dividend.
- `req_src2`  in  32  multiplier or divisor.
- `flush`  in  1  exception/cancel; aborts any operation.
- `hold`  in  1  stall from a later stage; the execute instruction cannot advance.
- `stallreq_o`  out  1  request to stall IF/ID/EXE.
- `res_valid`  out  1  result valid. The instruction may advance this cycle.
- `res_hilo`  out  64  {HI, LO}: product, or {remainder, quotient}.
- `div_zero`  out  1  qualifies `res_valid` when the divisor is 0.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **IDLE**
  - `req_valid`=1 and no `flush`: register the operands and the op.
  - Go to MUL when `req_op[1]`=0, otherwise go to DIV.
- **MUL**
  - Form the 33x33 signed product of the sign- or zero-extended operands.
  - Register the low 64 bits into the result register, then go to DONE.
- **DIV**
  - Take magnitudes of the operands (signed ops only), then run the core for 16 iterations of 2 quotient bits each.
  - One fixup cycle follows: negate the quotient when the signs differ (signed only); give the remainder the sign of the dividend. Then go to DONE.
  - Divisor 0: no iterations. Result is HI=`req_src1`, LO=32'hFFFF_FFFF, and `div_zero`=1. Go to DONE the next cycle.
  - DIV of 0x8000_0000 by 0xFFFF_FFFF gives HI=0, LO=0x8000_0000 (wraps; no trap).
- **DONE**
  - `res_valid`=1 and `res_hilo` driven from the result register.
  - `hold`=0: go to IDLE.
  - `hold`=1: stay in DONE with the result held.
- **Outputs**
  - `stallreq_o` = `req_valid` & (state≠DONE) & ~`flush`.
  - `res_valid` and `div_zero` are 0 outside DONE. `res_hilo` is 0 outside DONE.
- **Flush**
  - `flush`=1 in any state: next state is IDLE, the result register clears, and no `res_valid` is produced.
  - `flush` takes priority over accepting a request.
- **Reset**
  - All outputs are 0 and the state is IDLE, including reset asserted mid-division.

## Timing
- Request accepted at cycle T (IDLE).
- MULT/MULTU: MUL at T+1, `res_valid` at T+2. `stallreq_o` is high during T and T+1.
- DIV/DIVU: DIV from T+1 to T+17 (16 iterations plus fixup), `res_valid` at T+18.
- Divide by zero: `res_valid` at T+2.
- DONE→IDLE takes one cycle, so back-to-back requests have one idle accept cycle between them. The next request is accepted at the first IDLE cycle.
- `res_valid` is a single-cycle pulse unless `hold` extends it.

## Configuration
- Macro: `MULDIV_FAST_DIV_EN`.
- Defined: at accept, if |dividend| < |divisor| and the divisor is nonzero, skip the iterations. Result is quotient 0, remainder = dividend (original sign), with `res_valid` at T+2.
- Undefined: every nonzero-divisor division takes the full T+18 latency.

## Structure
- Shared package holds:
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encodings;
  - `DIV_ITERS`=16;
  - `DIV_ZERO_LO`=32'hFFFF_FFFF.
- Sub-module `div_radix4_core`:
  - inputs: magnitude dividend/divisor and a start pulse;
  - internals: precomputed 1x/2x/3x divisor and a 66-bit partial remainder/quotient shift register;
  - outputs: unsigned quotient/remainder and a done pulse;
  - the controller owns the sign handling and the flush abort.

## Test plan
- MULT 0xFFFF_FFFE × 0x0000_0003 → `res_valid` at T+2, `res_hilo`=0xFFFF_FFFF_FFFF_FFFA; MULTU of the same → 0x0000_0002_FFFF_FFFA.
- DIV −7 / 2 → at T+18 HI=0xFFFF_FFFF, LO=0xFFFF_FFFD; DIVU 100 / 7 → HI=2, LO=14; `stallreq_o` high for exactly 18 cycles.
- DIV x / 0 with x=0x1234_5678 → `res_valid` at T+2, `div_zero`=1, HI=0x1234_5678, LO=0xFFFF_FFFF.
- `flush` at T+5 of a DIV → IDLE at T+6, no `res_valid`; a new MULT accepted at T+6 completes at T+8 with the correct value.
- `hold`=1 for 3 cycles in DONE → `res_valid` and `res_hilo` stable for 4 cycles, then IDLE; no re-issue of the same instruction.
- With `MULDIV_FAST_DIV_EN`: DIVU 3 / 10 → HI=3, LO=0 at T+2. Without it: the same result at T+18.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants for the multiply/divide controller: op and state encodings,
// divider iteration count and the divide-by-zero LO value.
package muldiv_ctrl_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DIV  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam int unsigned DIV_ITERS   = 16;
  localparam int unsigned DIV_CNT_W   = 5;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // Magnitude of a 32-bit operand; only negates when the op is signed.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix4_core.sv
// Unsigned radix-4 restoring divider: 16 iterations, 2 quotient bits each.
// Sign handling and flush abort belong to the controller.
module div_radix4_core
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [33:0]          d1_q, d2_q, d3_q;
  logic [65:0]          shreg;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 busy;
  logic [35:0]          part;
  logic [33:0]          diff;
  logic [1:0]           qb;

  // Partial remainder stays below the divisor, so the top two bits of part are
  // always zero; they are kept in the compare to use the full register.
  always_comb begin
    part = shreg[65:30];
    qb   = 2'd0;
    diff = part[33:0];
    if (part >= {2'b00, d3_q}) begin
      qb   = 2'd3;
      diff = part[33:0] - d3_q;
    end else if (part >= {2'b00, d2_q}) begin
      qb   = 2'd2;
      diff = part[33:0] - d2_q;
    end else if (part >= {2'b00, d1_q}) begin
      qb   = 2'd1;
      diff = part[33:0] - d1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q  <= '0;
      d2_q  <= '0;
      d3_q  <= '0;
      shreg <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      d1_q  <= {2'b00, divisor};
      d2_q  <= {1'b0, divisor, 1'b0};
      d3_q  <= {2'b00, divisor} + {1'b0, divisor, 1'b0};
      shreg <= {34'd0, dividend};
      cnt   <= DIV_CNT_W'(DIV_ITERS);
      busy  <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        shreg <= {diff, shreg[29:0], qb};
        cnt   <= cnt - 1'b1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign quotient  = shreg[31:0];
  assign remainder = shreg[63:32];
  assign done      = busy && (cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller with pipeline stall and flush.
// Optional macro MULDIV_FAST_DIV_EN: skip iterations when |dividend| < |divisor|.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  input  logic        hold,
  output logic        stallreq_o,
  output logic        res_valid,
  output logic [63:0] res_hilo,
  output logic        div_zero
);

  logic [1:0]  state;
  logic        sgn_q, dz_q, fast_q;
  logic [31:0] a_q, b_q;
  logic [63:0] res_q;

  logic        req_sgn, accept, fast_hit, core_start, core_done;
  logic [31:0] mag_a, mag_b, core_quo, core_rem, quo_fix, rem_fix;
  logic [63:0] mul_a, mul_b, prod;

  assign req_sgn = ~req_op[0];
  assign accept  = (state == ST_IDLE) && req_valid && !flush;
  assign mag_a   = mag32(req_src1, req_sgn);
  assign mag_b   = mag32(req_src2, req_sgn);

`ifdef MULDIV_FAST_DIV_EN
  assign fast_hit = (mag_a < mag_b);
`else
  assign fast_hit = 1'b0;
`endif

  assign core_start = accept && req_op[1] && (req_src2 != '0) && !fast_hit;

  div_radix4_core u_core (
    .clk       (cpu_clk_50M),
    .rst       (cpu_rst),
    .start     (core_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (core_quo),
    .remainder (core_rem),
    .done      (core_done)
  );

  // Low 64 bits of a 64x64 product of extended operands equal the 33x33 product.
  assign mul_a   = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b   = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod    = mul_a * mul_b;
  assign quo_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? (~core_quo + 32'd1) : core_quo;
  assign rem_fix = (sgn_q && a_q[31]) ? (~core_rem + 32'd1) : core_rem;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state  <= ST_IDLE;
      sgn_q  <= 1'b0;
      dz_q   <= 1'b0;
      fast_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      res_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          sgn_q  <= req_sgn;
          a_q    <= req_src1;
          b_q    <= req_src2;
          fast_q <= fast_hit;
          res_q  <= '0;
          dz_q   <= 1'b0;
          state  <= req_op[1] ? ST_DIV : ST_MUL;
        end
        ST_MUL: begin
          res_q <= prod;
          state <= ST_DONE;
        end
        ST_DIV: begin
          if (b_q == '0) begin
            res_q <= {a_q, DIV_ZERO_LO};
            dz_q  <= 1'b1;
            state <= ST_DONE;
          end else if (fast_q) begin
            res_q <= {a_q, 32'd0};
            state <= ST_DONE;
          end else if (core_done) begin
            res_q <= {rem_fix, quo_fix};
            state <= ST_DONE;
          end
        end
        default: if (!hold) state <= ST_IDLE;
      endcase
    end
  end

  assign stallreq_o = !cpu_rst && req_valid && (state != ST_DONE) && !flush;
  assign res_valid  = !cpu_rst && !flush && (state == ST_DONE);
  assign div_zero   = res_valid && dz_q;
  assign res_hilo   = (!cpu_rst && (state == ST_DONE)) ? res_q : '0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized bench for muldiv_ctrl against an arithmetic reference.
module tb_muldiv_ctrl;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst, req_valid, flush, hold;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        stallreq_o, res_valid, div_zero;
  logic [63:0] res_hilo;

  int checks   = 0;
  int failures = 0;

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  muldiv_ctrl dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .flush       (flush),
    .hold        (hold),
    .stallreq_o  (stallreq_o),
    .res_valid   (res_valid),
    .res_hilo    (res_hilo),
    .div_zero    (div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk_50M);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on extended operands.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] hl, output logic dz, output int lat);
    longint sa, sb, q, r, ma, mb;
    sa  = op[0] ? longint'({32'd0, a}) : longint'(signed'(a));
    sb  = op[0] ? longint'({32'd0, b}) : longint'(signed'(b));
    dz  = 1'b0;
    lat = 2;
    if (!op[1]) begin
      hl = 64'(sa * sb);
    end else if (b == 32'd0) begin
      hl  = {a, 32'hFFFF_FFFF};
      dz  = 1'b1;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      hl  = {r[31:0], q[31:0]};
      lat = 18;
      ma  = (sa < 0) ? -sa : sa;
      mb  = (sb < 0) ? -sb : sb;
`ifdef MULDIV_FAST_DIV_EN
      if (ma < mb) lat = 2;
`else
      if (ma < mb) lat = 18;
`endif
    end
  endfunction

  // Issue one request at the current cycle T and follow it through DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold_n, input string tag);
    logic [63:0] exp_hl;
    logic        exp_dz;
    int          lat, cyc, stall_n;
    bit          seen;
    model(op, a, b, exp_hl, exp_dz, lat);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    #1;
    stall_n = stallreq_o ? 1 : 0;
    cyc     = 0;
    seen    = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (res_valid) seen = 1'b1;
      else if (stallreq_o) stall_n++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    if (!seen) begin
      req_valid = 1'b0;
      flush     = 1'b1;
      tick();
      flush = 1'b0;
      return;
    end
    chk({tag, " stall_cycles"}, 64'(stall_n), 64'(lat));
    chk({tag, " hilo"}, res_hilo, exp_hl);
    chk({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
    chk({tag, " stall_in_done"}, 64'(stallreq_o), 64'd0);
    for (int h = 0; h < hold_n; h++) begin
      hold = 1'b1;
      tick();
      chk({tag, " held_valid"}, 64'(res_valid), 64'd1);
      chk({tag, " held_hilo"}, res_hilo, exp_hl);
    end
    hold      = 1'b0;
    req_valid = 1'b0;
    tick();
    chk({tag, " valid_after"}, 64'(res_valid), 64'd0);
    chk({tag, " hilo_after"}, res_hilo, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    cpu_rst   = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_src1  = 32'd5;
    req_src2  = 32'd1;
    flush     = 1'b0;
    hold      = 1'b0;
    tick();
    tick();
    chk("reset stall", 64'(stallreq_o), 64'd0);
    chk("reset valid", 64'(res_valid), 64'd0);
    chk("reset hilo", res_hilo, 64'd0);
    chk("reset dz", 64'(div_zero), 64'd0);
    req_valid = 1'b0;
    cpu_rst   = 1'b0;
    tick();

    run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 0, "mult");
    run_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 0, "multu");
    chk("multu const", 64'h0000_0002_FFFF_FFFA, 64'((64'hFFFF_FFFE) * 64'd3));
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
    run_op(2'b11, 32'd100, 32'd7, 0, "divu_100_7");
    run_op(2'b10, 32'h1234_5678, 32'd0, 0, "div_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(2'b11, 32'd3, 32'd10, 0, "divu_3_10");
    run_op(2'b00, 32'h0001_0003, 32'h7FFF_0011, 3, "hold3");

    // Flush a DIV at T+5, then a MULT accepted at T+6.
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_src1  = 32'hFFFF_FF9C;
    req_src2  = 32'd3;
    #1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("flush pre_valid", 64'(res_valid), 64'd0);
    end
    flush     = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("flush stall", 64'(stallreq_o), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush no_valid", 64'(res_valid), 64'd0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, "post_flush_mult");

    // Reset in the middle of a division.
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_src1  = 32'd1000;
    req_src2  = 32'd3;
    #1;
    for (int i = 0; i < 6; i++) tick();
    cpu_rst = 1'b1;
    #1;
    chk("midrst stall", 64'(stallreq_o), 64'd0);
    chk("midrst valid", 64'(res_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    cpu_rst   = 1'b0;
    tick();
    chk("midrst idle_valid", 64'(res_valid), 64'd0);
    run_op(2'b11, 32'd1000, 32'd3, 1, "after_rst_divu");

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = ~32'($urandom_range(0, 15));
        3:       ra = 32'($urandom_range(0, 99));
        default: rb = $urandom;
      endcase
      if (rb === 32'bx) rb = $urandom;
      run_op(rop, ra, rb, $urandom_range(0, 2), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
